sha256_stream: RTL and testbench

Multi-block SHA-256 engine with built-in message padding. It accepts a byte-granular message of arbitrary length as a stream of 32-bit words with a valid/ready handshake and chains 512-bit blocks through an iterative compression loop. It generates the 0x80/zero/length padding itself and presents the 256-bit digest with a one-cycle finish interrupt. It sits behind the AXI-lite/stream front end and replaces the fixed single-chunk core for software-driven hashing.

---
 rtl/sha256_stream.sv | 276 +++++++++++++++++++++++++++
 tb/tb_sha256_stream.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_stream.sv
// Streaming multi-block SHA-256 engine with in-engine 0x80/zero/length padding.
// Define SHA256_STREAM_SHA224_EN to add mode_i and SHA-224 digests.
module sha256_stream #(
  parameter int LEN_W     = 32,
  parameter bit BYTE_SWAP = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
`ifdef SHA256_STREAM_SHA224_EN
  input  logic         mode_i,
`endif
  input  logic         dat_valid_i,
  output logic         dat_ready_o,
  input  logic [31:0]  dat_i,
  input  logic         dat_last_i,
  input  logic [3:0]   dat_keep_i,
  output logic [255:0] hash_o,
  output logic         hash_valid_o,
  output logic         busy_o,
  output logic         irq_finish
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PAD, S_PROC, S_UPD, S_DONE
  } state_e;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [0:7][31:0] IV256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

`ifdef SHA256_STREAM_SHA224_EN
  localparam logic [0:7][31:0] IV224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };
`endif

  function automatic logic [31:0] rotr(
    input logic [31:0] x,
    input int unsigned n
  );
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [0:7][31:0] round_f(
    input logic [0:7][31:0] s,
    input logic [31:0]      k,
    input logic [31:0]      w
  );
    logic [31:0] t1, t2, ch, maj;
    ch  = (s[4] & s[5]) ^ (~s[4] & s[6]);
    maj = (s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]);
    t1  = s[7] + bsig1(s[4]) + ch + k + w;
    t2  = bsig0(s[0]) + maj;
    return {t1 + t2, s[0], s[1], s[2], s[3] + t1, s[4], s[5], s[6]};
  endfunction

  state_e           state_q, state_d;
  logic [31:0]      w_q [16];
  logic [31:0]      w_d [16];
  logic [0:7][31:0] h_q, h_d, v_q, v_d;
  logic [255:0]     hash_q, hash_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [3:0]       widx_q, widx_d;
  logic [5:0]       rnd_q, rnd_d;
  logic             end_q, end_d;
  logic             mark_q, mark_d;
  logic             lenw_q, lenw_d;
  logic             fin_q, fin_d;
  logic             hval_q, hval_d;
`ifdef SHA256_STREAM_SHA224_EN
  logic             mode_q, mode_d;
`endif

  logic [31:0] din, dmask, dmark, dword;
  logic [31:0] wnew, wt;
  logic [2:0]  kcnt;
  logic [3:0]  j;
  logic [63:0] bitlen;

  assign din = BYTE_SWAP ? {dat_i[7:0], dat_i[15:8],
                            dat_i[23:16], dat_i[31:24]} : dat_i;

  // kcnt==4 shifts everything out: full mask, no marker byte
  assign kcnt  = dat_last_i ? 3'(dat_keep_i[0]) + 3'(dat_keep_i[1])
                            + 3'(dat_keep_i[2]) + 3'(dat_keep_i[3])
                            : 3'd4;
  assign dmask = ~(32'hffff_ffff >> {kcnt, 3'b000});
  assign dmark = 32'h8000_0000 >> {kcnt, 3'b000};
  assign dword = (din & dmask) | dmark;

  assign bitlen = 64'(len_q) << 3;

  assign j    = rnd_q[3:0];
  assign wnew = ssig1(w_q[j + 4'd14]) + w_q[j + 4'd9]
              + ssig0(w_q[j + 4'd1]) + w_q[j];
  assign wt   = (rnd_q[5:4] == 2'b00) ? w_q[j] : wnew;

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    v_d     = h_q;
    hash_d  = hash_q;
    len_d   = len_q;
    widx_d  = widx_q;
    rnd_d   = rnd_q;
    end_d   = end_q;
    mark_d  = mark_q;
    lenw_d  = lenw_q;
    fin_d   = fin_q;
    hval_d  = hval_q;
`ifdef SHA256_STREAM_SHA224_EN
    mode_d  = mode_q;
`endif
    case (state_q)
      S_LOAD: begin
        if (dat_valid_i) begin
          w_d[widx_q] = dword;
          len_d       = len_q + LEN_W'(kcnt);
          widx_d      = widx_q + 4'd1;
          if (dat_last_i) begin
            end_d   = 1'b1;
            mark_d  = (kcnt != 3'd4);
            state_d = (widx_q == 4'd15) ? S_PROC : S_PAD;
          end else if (widx_q == 4'd15) begin
            state_d = S_PROC;
          end
        end
      end
      S_PAD: begin
        widx_d = widx_q + 4'd1;
        if (widx_q == 4'd14 && mark_q) begin
          w_d[14] = bitlen[63:32];
          lenw_d  = 1'b1;
        end else if (widx_q == 4'd15 && lenw_q) begin
          w_d[15] = bitlen[31:0];
          fin_d   = 1'b1;
          state_d = S_PROC;
        end else begin
          w_d[widx_q] = mark_q ? 32'h0 : 32'h8000_0000;
          mark_d      = 1'b1;
          if (widx_q == 4'd15) state_d = S_PROC;
        end
      end
      S_PROC: begin
        v_d   = round_f(v_q, K[rnd_q], wt);
        rnd_d = rnd_q + 6'd1;
        if (rnd_q >= 6'd16) w_d[j] = wt;
        if (rnd_q == 6'd63) state_d = S_UPD;
      end
      S_UPD: begin
        for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + v_q[i];
        widx_d = 4'd0;
        lenw_d = 1'b0;
        if (fin_q) begin
          state_d = S_DONE;
          hval_d  = 1'b1;
          hash_d  = h_d;
`ifdef SHA256_STREAM_SHA224_EN
          if (mode_q) hash_d = {h_d[0:6], 32'h0};
`endif
        end else if (end_q) begin
          state_d = S_PAD;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // start wins over any in-flight work, including a same-cycle handshake
    if (start_i) begin
      state_d = S_LOAD;
      h_d     = IV256;
      hash_d  = '0;
      len_d   = '0;
      widx_d  = 4'd0;
      rnd_d   = 6'd0;
      end_d   = 1'b0;
      mark_d  = 1'b0;
      lenw_d  = 1'b0;
      fin_d   = 1'b0;
      hval_d  = 1'b0;
`ifdef SHA256_STREAM_SHA224_EN
      mode_d  = mode_i;
      if (mode_i) h_d = IV224;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      h_q     <= '0;
      v_q     <= '0;
      hash_q  <= '0;
      len_q   <= '0;
      widx_q  <= '0;
      rnd_q   <= '0;
      end_q   <= 1'b0;
      mark_q  <= 1'b0;
      lenw_q  <= 1'b0;
      fin_q   <= 1'b0;
      hval_q  <= 1'b0;
`ifdef SHA256_STREAM_SHA224_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      hash_q  <= hash_d;
      len_q   <= len_d;
      widx_q  <= widx_d;
      rnd_q   <= rnd_d;
      end_q   <= end_d;
      mark_q  <= mark_d;
      lenw_q  <= lenw_d;
      fin_q   <= fin_d;
      hval_q  <= hval_d;
`ifdef SHA256_STREAM_SHA224_EN
      mode_q  <= mode_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    w_q <= w_d;
  end

  assign dat_ready_o  = (state_q == S_LOAD);
  assign busy_o       = (state_q == S_LOAD) || (state_q == S_PAD)
                     || (state_q == S_PROC) || (state_q == S_UPD);
  assign irq_finish   = (state_q == S_DONE);
  assign hash_valid_o = hval_q;
  assign hash_o       = hash_q;

endmodule

// File: tb/tb_sha256_stream.sv
// Bench for sha256_stream: random messages against a queue-based SHA model.
// Define SHA256_STREAM_SHA224_EN to also exercise SHA-224 mode.
module tb_sha256_stream;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] IVA [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [31:0] IVB [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };
  localparam logic [255:0] D_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_56 =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] D_224 =
    {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic         mode_i = 1'b0;
  logic         dat_valid_i = 1'b0;
  logic         dat_ready_o;
  logic [31:0]  dat_i = '0;
  logic         dat_last_i = 1'b0;
  logic [3:0]   dat_keep_i = '0;
  logic [255:0] hash_o;
  logic         hash_valid_o;
  logic         busy_o;
  logic         irq_finish;

  int vectors = 0;
  int miscompares = 0;
  int irq_cnt = 0;
  int cyc_ctr = 0;
  int t_start = 0;
  int t_irq = 0;
  logic [255:0] exp_hash = '0;

  sha256_stream #(.LEN_W(32), .BYTE_SWAP(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
`ifdef SHA256_STREAM_SHA224_EN
    .mode_i       (mode_i),
`endif
    .dat_valid_i  (dat_valid_i),
    .dat_ready_o  (dat_ready_o),
    .dat_i        (dat_i),
    .dat_last_i   (dat_last_i),
    .dat_keep_i   (dat_keep_i),
    .hash_o       (hash_o),
    .hash_valid_o (hash_valid_o),
    .busy_o       (busy_o),
    .irq_finish   (irq_finish)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook SHA-256/224 over a byte queue: pad, expand 64 words, compress
  function automatic logic [255:0] sha_ref(input byte unsigned m[$], input bit is224);
    byte unsigned p[$];
    logic [31:0] h [8];
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    logic [63:0] bl;
    logic [255:0] r;
    p = m;
    bl = 64'(m.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    for (int i = 0; i < 8; i++) h[i] = is224 ? IVB[i] : IVA[i];
    for (int blk = 0; blk < p.size() / 64; blk++) begin
      for (int t = 0; t < 16; t++)
        w[t] = {p[64*blk+4*t], p[64*blk+4*t+1], p[64*blk+4*t+2], p[64*blk+4*t+3]};
      for (int t = 16; t < 64; t++) begin
        s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
        s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
        w[t] = s1 + w[t-7] + s0 + w[t-16];
      end
      a = h[0]; b = h[1]; c = h[2]; d = h[3];
      e = h[4]; f = h[5]; g = h[6]; hh = h[7];
      for (int t = 0; t < 64; t++) begin
        t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25))
           + ((e & f) ^ (~e & g)) + KT[t] + w[t];
        t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22))
           + ((a & b) ^ (a & c) ^ (b & c));
        hh = g; g = f; f = e; e = d + t1;
        d = c; c = b; b = a; a = t1 + t2;
      end
      h[0] += a; h[1] += b; h[2] += c; h[3] += d;
      h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
    end
    r = {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
    if (is224) r[31:0] = 32'h0;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  // Per-cycle check: a held digest must equal the model's digest
  always @(posedge clk) begin
    cyc_ctr = cyc_ctr + 1;
    #1;
    if (rst_n === 1'b1 && (hash_valid_o === 1'b1 || irq_finish === 1'b1)) begin
      vectors++;
      if (hash_o !== exp_hash || busy_o !== 1'b0 || hash_valid_o !== 1'b1) begin
        miscompares++;
        $display("FAIL held_digest: got %h v=%b b=%b want %h", hash_o,
                 hash_valid_o, busy_o, exp_hash);
      end
    end
    if (rst_n === 1'b1 && irq_finish === 1'b1) begin
      irq_cnt++;
      t_irq = cyc_ctr;
    end
  end

  task automatic send_msg(input byte unsigned m[$], input bit m224,
                          input int gap, input bit xtra, input int stop);
    logic [31:0] wq[$];
    logic [3:0]  kq[$];
    logic [31:0] wd;
    logic [3:0]  kv;
    int n, idx, g;
    bit v;
    n = m.size();
    for (int i = 0; i < n; i += 4) begin
      wd = $urandom;
      kv = 4'b0000;
      for (int b = 0; b < 4; b++) begin
        if (i + b < n) begin
          wd[8*b +: 8] = m[i+b];
          kv[b] = 1'b1;
        end
      end
      wq.push_back(wd);
      kq.push_back(kv);
    end
    if (n == 0 || (xtra && n % 4 == 0)) begin
      wq.push_back($urandom);
      kq.push_back(4'b0000);
    end
    @(negedge clk);
    start_i = 1'b1;
    mode_i = m224;
    exp_hash = sha_ref(m, m224);
    t_start = cyc_ctr;
    dat_valid_i = 1'b1;
    dat_i = $urandom;
    dat_last_i = 1'($urandom_range(1));
    dat_keep_i = 4'($urandom);
    @(negedge clk);
    start_i = 1'b0;
    idx = 0;
    g = 0;
    while (idx < wq.size() && idx != stop && g < 4000) begin
      v = ($urandom_range(99) >= gap);
      dat_valid_i = v;
      dat_i = v ? wq[idx] : $urandom;
      dat_last_i = (idx == wq.size() - 1);
      dat_keep_i = dat_last_i ? kq[idx] : 4'($urandom);
      if (v && dat_ready_o) idx++;
      @(negedge clk);
      g++;
    end
    dat_valid_i = 1'b0;
    chk("feed_in_time", 256'(g < 4000), 256'(1));
  endtask

  task automatic wait_done(input string nm, input bit hold);
    int n, rdy, i0;
    i0 = irq_cnt;
    n = 0;
    rdy = 0;
    while (irq_cnt == i0 && n < 3000) begin
      @(negedge clk);
      if (hold) begin
        dat_valid_i = 1'b1;
        dat_i = $urandom;
        dat_last_i = 1'($urandom_range(1));
        dat_keep_i = 4'($urandom);
      end
      if (dat_ready_o) rdy++;
      n++;
    end
    chk({nm, "_done"}, 256'(n < 3000), 256'(1));
    chk({nm, "_no_ready_after_last"}, 256'(rdy), 256'(0));
    chk({nm, "_digest"}, hash_o, exp_hash);
    repeat (3) @(negedge clk);
    dat_valid_i = 1'b0;
    chk({nm, "_one_irq"}, 256'(irq_cnt - i0), 256'(1));
    chk({nm, "_valid_idle"}, 256'({hash_valid_o, busy_o}), 256'(2'b10));
  endtask

  initial begin
    byte unsigned abc[$];
    byte unsigned emp[$];
    byte unsigned m56[$];
    byte unsigned mr[$];
    string s56;
    int len;
    bit m224;

    abc = '{8'h61, 8'h62, 8'h63};
    s56 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    for (int i = 0; i < s56.len(); i++) m56.push_back(s56[i]);

    dat_valid_i = 1'b1;
    dat_i = 32'hdeadbeef;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", 256'({dat_ready_o, hash_valid_o, busy_o, irq_finish}), 256'(0));
    chk("reset_hash", hash_o, 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ignores_valid", 256'({dat_ready_o, busy_o}), 256'(0));
    dat_valid_i = 1'b0;

    chk("model_abc", sha_ref(abc, 1'b0), D_ABC);
    chk("model_empty", sha_ref(emp, 1'b0), D_EMPTY);
    chk("model_56", sha_ref(m56, 1'b0), D_56);
    chk("model_224", sha_ref(abc, 1'b1), D_224);

    send_msg(abc, 1'b0, 0, 1'b0, -1);
    wait_done("abc", 1'b0);
    chk("abc_literal", hash_o, D_ABC);
    chk("abc_latency", 256'((t_irq - t_start) >= 81 && (t_irq - t_start) <= 97), 256'(1));

    send_msg(emp, 1'b0, 0, 1'b0, -1);
    wait_done("empty", 1'b0);
    chk("empty_literal", hash_o, D_EMPTY);

    send_msg(m56, 1'b0, 0, 1'b0, -1);
    wait_done("m56", 1'b0);
    chk("m56_literal", hash_o, D_56);

    send_msg(m56, 1'b0, 50, 1'b1, -1);
    wait_done("m56_bp", 1'b1);
    chk("m56_bp_literal", hash_o, D_56);

    mr.delete();
    for (int i = 0; i < 100; i++) mr.push_back(8'($urandom));
    send_msg(mr, 1'b0, 0, 1'b0, -1);
    repeat (30) @(negedge clk);
    chk("abort_mid_proc", 256'({hash_valid_o, busy_o}), 256'(2'b01));
    send_msg(abc, 1'b0, 0, 1'b0, -1);
    wait_done("abort_proc_abc", 1'b0);
    chk("abort_proc_literal", hash_o, D_ABC);

    send_msg(mr, 1'b0, 0, 1'b0, 3);
    send_msg(abc, 1'b0, 0, 1'b0, -1);
    wait_done("abort_load_abc", 1'b0);
    chk("abort_load_literal", hash_o, D_ABC);

    send_msg(mr, 1'b0, 0, 1'b0, 5);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midload_reset_ctrl",
        256'({dat_ready_o, hash_valid_o, busy_o, irq_finish}), 256'(0));
    chk("midload_reset_hash", hash_o, 256'(0));
    @(negedge clk);
    rst_n = 1'b1;

`ifdef SHA256_STREAM_SHA224_EN
    send_msg(abc, 1'b1, 0, 1'b0, -1);
    wait_done("sha224", 1'b0);
    chk("sha224_literal", hash_o, D_224);
`endif

    for (int k = 0; k < 16; k++) begin
      mr.delete();
      len = (k < 4) ? 52 + 4 * k : $urandom_range(150);
      for (int i = 0; i < len; i++) mr.push_back(8'($urandom));
      m224 = 1'b0;
`ifdef SHA256_STREAM_SHA224_EN
      m224 = 1'($urandom_range(1));
`endif
      send_msg(mr, m224, $urandom_range(60), 1'($urandom_range(1)), -1);
      wait_done("rand", 1'($urandom_range(1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
